wordcount_xfer_sched: RTL

Sequencing controller for the wordcount kernel. On kick it splits the input word buffer into bounded read transfers for the AXI read master and starts the counting core. It waits for the core to finish, then issues one writeback transfer to the AXI write master. It owns the kick/busy handshake toward the host-side control registers.

---
 rtl/wordcount_pkg.sv | 32 +++
 rtl/wordcount_chunk_gen.sv | 49 ++++
 rtl/wordcount_xfer_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wordcount_pkg.sv
// ============================================================================
// Module   : wordcount_pkg
// Purpose  : Shared types, constants and helpers for the wordcount scheduler
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wordcount_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DISPATCH  = 3'd1,
        RD_ISSUE  = 3'd2,
        RD_WAIT   = 3'd3,
        CORE_WAIT = 3'd4,
        WR_ISSUE  = 3'd5,
        WR_WAIT   = 3'd6,
        DONE      = 3'd7
    } state_t;

    localparam logic [31:0] CMD_COUNT      = 32'd1;
    localparam logic [31:0] CMD_COUNT_NOWB = 32'd2;
    localparam int          WORD_BYTES     = 4;
    localparam int          BEAT_BYTES     = 64;

    function automatic logic [63:0] roundup64(input logic [63:0] i_bytes);
        roundup64 = (i_bytes + 64'(BEAT_BYTES - 1)) & ~64'(BEAT_BYTES - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wordcount_chunk_gen.sv
// ============================================================================
// Module   : wordcount_chunk_gen
// Purpose  : Tracks read address / remaining bytes and sizes the next chunk
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wordcount_chunk_gen #(
    parameter int unsigned MAX_CHUNK_BYTES = 4096,
    parameter int unsigned ADDR_W          = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_total,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_size,
    output logic              o_last,
    output logic              o_empty
);

    localparam logic [ADDR_W-1:0] C_MAX = ADDR_W'(MAX_CHUNK_BYTES);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_remaining <= i_total;
        end else if (i_advance) begin
            r_addr      <= r_addr + o_size;
            r_remaining <= r_remaining - o_size;
        end
    end

    assign o_addr  = r_addr;
    assign o_size  = (r_remaining > C_MAX) ? C_MAX : r_remaining;
    assign o_last  = (r_remaining <= C_MAX);
    assign o_empty = (r_remaining == '0);

endmodule

`default_nettype wire

// File: rtl/wordcount_xfer_sched.sv
// ============================================================================
// Module   : wordcount_xfer_sched
// Purpose  : Splits a job into read chunks, runs the core, issues writeback
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wordcount_xfer_sched
    import wordcount_pkg::*;
#(
    parameter int unsigned MAX_CHUNK_BYTES = 4096,
    parameter logic [63:0] WR_BASE_OFFSET  = 64'h0000_0000_1000_0000,
    parameter int unsigned ADDR_W          = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              kick,
    output logic              busy,
    input  logic [31:0]       command,
    input  logic [31:0]       num_of_words,
    input  logic [ADDR_W-1:0] global_memory_offset,
    output logic              reader_ctrl_start,
    input  logic              reader_ctrl_done,
    output logic [ADDR_W-1:0] reader_ctrl_addr_offset,
    output logic [ADDR_W-1:0] reader_ctrl_xfer_size_in_bytes,
    output logic              writer_ctrl_start,
    input  logic              writer_ctrl_done,
    output logic [ADDR_W-1:0] writer_ctrl_addr_offset,
    output logic [ADDR_W-1:0] writer_ctrl_xfer_size_in_bytes,
    output logic              core_start,
    input  logic              core_done,
    input  logic [ADDR_W-1:0] result_bytes,
    output logic [15:0]       chunk_count
);

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_cmd;
    logic [ADDR_W-1:0] r_offset;
    logic [ADDR_W-1:0] r_result;
    logic              r_core_done;
    logic [15:0]       r_chunk_count;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_rd_size;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_wr_size;

    logic              w_kick_accept;
    logic              w_cmd_valid;
    logic              w_core_start;
    logic              w_core_window;
    logic              w_core_seen;
    logic [ADDR_W-1:0] w_result;
    logic [ADDR_W-1:0] w_total;
    logic              w_rd_advance;
    logic [ADDR_W-1:0] w_chunk_addr;
    logic [ADDR_W-1:0] w_chunk_size;
    logic              w_chunk_last;
    logic              w_chunk_empty;

    assign w_kick_accept = (r_state == IDLE) && kick;
    assign w_cmd_valid   = (r_cmd == CMD_COUNT) || (r_cmd == CMD_COUNT_NOWB);
    assign w_core_start  = (r_state == DISPATCH) && w_cmd_valid && !w_chunk_empty;
    assign w_rd_advance  = (r_state == RD_WAIT) && reader_ctrl_done;
    // A core_done arriving in the same cycle CORE_WAIT checks still counts
    assign w_core_seen   = r_core_done || core_done;
    assign w_result      = r_core_done ? r_result : result_bytes;
    assign w_core_window = w_core_start || (r_state == RD_ISSUE) ||
                           (r_state == RD_WAIT) || (r_state == CORE_WAIT);
    assign w_total       = ADDR_W'(roundup64(64'(num_of_words) * 64'(WORD_BYTES)));

    wordcount_chunk_gen #(
        .MAX_CHUNK_BYTES (MAX_CHUNK_BYTES),
        .ADDR_W          (ADDR_W)
    ) u_chunk_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_kick_accept),
        .i_base    (global_memory_offset),
        .i_total   (w_total),
        .i_advance (w_rd_advance),
        .o_addr    (w_chunk_addr),
        .o_size    (w_chunk_size),
        .o_last    (w_chunk_last),
        .o_empty   (w_chunk_empty)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (kick) w_next = DISPATCH;
            DISPATCH:  w_next = w_core_start ? RD_ISSUE : DONE;
            RD_ISSUE:  w_next = RD_WAIT;
            RD_WAIT:   if (reader_ctrl_done) w_next = w_chunk_last ? CORE_WAIT : RD_ISSUE;
            CORE_WAIT: begin
                if (w_core_seen) begin
                    if ((r_cmd == CMD_COUNT_NOWB) || (w_result == '0)) w_next = DONE;
                    else                                                w_next = WR_ISSUE;
                end
            end
            WR_ISSUE:  w_next = WR_WAIT;
            WR_WAIT:   if (writer_ctrl_done) w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cmd         <= '0;
            r_offset      <= '0;
            r_result      <= '0;
            r_core_done   <= 1'b0;
            r_chunk_count <= '0;
            r_rd_addr     <= '0;
            r_rd_size     <= '0;
            r_wr_addr     <= '0;
            r_wr_size     <= '0;
        end else begin
            r_state <= w_next;
            if (w_kick_accept) begin
                r_cmd         <= command;
                r_offset      <= global_memory_offset;
                r_result      <= '0;
                r_core_done   <= 1'b0;
                r_chunk_count <= '0;
            end else begin
                if (w_core_window && core_done && !r_core_done) begin
                    r_core_done <= 1'b1;
                    r_result    <= result_bytes;
                end
                if (r_state == RD_ISSUE) begin
                    r_chunk_count <= r_chunk_count + 16'd1;
                    r_rd_addr     <= w_chunk_addr;
                    r_rd_size     <= w_chunk_size;
                end
                if ((r_state == CORE_WAIT) && (w_next == WR_ISSUE)) begin
                    r_wr_addr <= r_offset + ADDR_W'(WR_BASE_OFFSET);
                    r_wr_size <= ADDR_W'(roundup64(64'(w_result)));
                end
            end
        end
    end

    // Chunk address/size are live during the issue cycle, then held from the snapshot
    assign reader_ctrl_start              = (r_state == RD_ISSUE);
    assign reader_ctrl_addr_offset        = (r_state == RD_ISSUE) ? w_chunk_addr : r_rd_addr;
    assign reader_ctrl_xfer_size_in_bytes = (r_state == RD_ISSUE) ? w_chunk_size : r_rd_size;
    assign writer_ctrl_start              = (r_state == WR_ISSUE);
    assign writer_ctrl_addr_offset        = r_wr_addr;
    assign writer_ctrl_xfer_size_in_bytes = r_wr_size;
    assign core_start                     = w_core_start;
    assign busy                           = (r_state != IDLE);
    assign chunk_count                    = r_chunk_count;

endmodule

`default_nettype wire
